// File: rtl/lane_demux_pkg.sv
// lane_demux_pkg
//   Shared definitions for the lane_demux_32 slice: lane count, selector
//   width, the FSM state type and the lane selector type.
//   Optional build macro used by the slice: LANE_DEMUX_PARITY_EN.
package lane_demux_pkg;

    localparam int LANES = 32;
    localparam int SEL_W = 5;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } lane_demux_state_t;

    typedef logic [SEL_W-1:0] lane_sel_t;

endpackage

// File: rtl/lane_demux_if.sv
// lane_demux_if
//   Bundles the bit-write handshake, the frame-output handshake and the
//   status/debug signals of lane_demux_32.
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high; valid is driven by the producer, ready by the
//   consumer, and neither depends combinationally on the other.
//   Signals:
//     in_valid/in_ready/in_bit/in_sel/auto_inc  bit-write side
//     clear                                     flush the frame in progress
//     out_lines/out_valid/out_ready             assembled 32-bit frame
//     wr_ptr                                    auto-increment pointer
//     state                                     FSM state (debug)
//     out_parity                                XOR of out_lines (only when
//                                               LANE_DEMUX_PARITY_EN is defined)
//   Modports: master = producer/consumer around the block, slave = block.
interface lane_demux_if;
    import lane_demux_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_bit;
    lane_sel_t         in_sel;
    logic              auto_inc;
    logic              clear;
    logic [LANES-1:0]  out_lines;
    logic              out_valid;
    logic              out_ready;
    lane_sel_t         wr_ptr;
    lane_demux_state_t state;
`ifdef LANE_DEMUX_PARITY_EN
    logic              out_parity;
`endif

    modport master (
        output in_valid, in_bit, in_sel, auto_inc, clear, out_ready,
        input  in_ready, out_lines, out_valid, wr_ptr, state
`ifdef LANE_DEMUX_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in_bit, in_sel, auto_inc, clear, out_ready,
        output in_ready, out_lines, out_valid, wr_ptr, state
`ifdef LANE_DEMUX_PARITY_EN
        , output out_parity
`endif
    );

endinterface

// File: rtl/decoder_5_to_32.sv
// decoder_5_to_32
//   Combinational 5-to-32 one-hot decoder with enable. Output bit sel is
//   high when en=1; all zero otherwise.
//   Ports: sel (lane index), en (enable), onehot (32-bit one-hot vector)
module decoder_5_to_32
    import lane_demux_pkg::*;
(
    input  lane_sel_t        sel,
    input  logic             en,
    output logic [LANES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/lane_demux_32.sv
// lane_demux_32
//   Registered 1-to-32 demultiplexer/deserializer. One bit is accepted per
//   in_valid/in_ready handshake and stored into a held output lane chosen
//   by in_sel (auto_inc=0) or by the internal pointer wr_ptr (auto_inc=1).
//   When every lane has been written at least once in the current frame,
//   the frame is presented with out_valid until out_ready takes it.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    lane_demux_if.slave (handshakes, lanes, wr_ptr, debug state)
//   Optional: define LANE_DEMUX_PARITY_EN to add the registered
//   bus.out_parity output (XOR of all out_lines bits).
module lane_demux_32
    import lane_demux_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    lane_demux_if.slave   bus
);

    lane_demux_state_t state_q;
    lane_demux_state_t next_state;
    logic [LANES-1:0]  lines_q;
    logic [LANES-1:0]  lines_next;
    logic [LANES-1:0]  mask_q;
    logic [LANES-1:0]  mask_next;
    lane_sel_t         ptr_q;
    lane_sel_t         lane;
    logic [LANES-1:0]  lane_onehot;
    logic              in_fill;
    logic              wr_en;
    logic              complete;
    logic              frame_taken;
    logic              in_ready;
    logic              out_valid;

    // Ready/valid come straight from the state register, so the accept
    // term below can use the state directly without a comb loop.
    assign in_fill     = (state_q == FILL);
    // An accept coinciding with clear is discarded.
    assign wr_en       = bus.in_valid && in_fill && !bus.clear;
    assign frame_taken = (state_q == HOLD) && bus.out_ready;
    assign lane        = bus.auto_inc ? ptr_q : bus.in_sel;

    decoder_5_to_32 u_decoder (
        .sel    (lane),
        .en     (wr_en),
        .onehot (lane_onehot)
    );

    // Rewriting a lane leaves the mask unchanged, so completion only
    // depends on every lane having been written at least once.
    assign mask_next  = mask_q | lane_onehot;
    assign complete   = wr_en && (&mask_next);
    assign lines_next = (lines_q & ~lane_onehot) | (lane_onehot & {LANES{bus.in_bit}});

    always_comb begin
        next_state = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (complete) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = FILL;
                end
            end
            default: begin
                next_state = FILL;
            end
        endcase
        if (bus.clear) begin
            next_state = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            lines_q <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= next_state;
            lines_q <= lines_next;
            if (bus.clear || frame_taken) begin
                mask_q <= '0;
                ptr_q  <= '0;
            end else if (wr_en) begin
                mask_q <= mask_next;
                if (bus.auto_inc) begin
                    ptr_q <= ptr_q + lane_sel_t'(1);
                end
            end
        end
    end

`ifdef LANE_DEMUX_PARITY_EN
    logic parity_q;

    // Computed from the next lane values so it changes on the same edge
    // as out_lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^lines_next;
        end
    end

    assign bus.out_parity = parity_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_lines = lines_q;
    assign bus.wr_ptr    = ptr_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_lane_demux_32.sv
// tb_lane_demux_32
//   Directed bench for lane_demux_32. Frames are driven through small
//   driver tasks; each expected frame is pushed into exp_q when its last
//   bit is issued and a monitor pops it when the DUT hands the frame over.
//   Optional: LANE_DEMUX_PARITY_EN also checks out_parity.
module tb_lane_demux_32;
    import lane_demux_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    lane_demux_if bus ();

    lane_demux_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b, input logic auto, input lane_sel_t sel);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.auto_inc = auto;
        bus.in_sel   = sel;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Auto-mode word, lane i gets w[i]; out_valid checked just before and
    // right after the completing accept.
    task automatic send_word(input logic [31:0] w, input string name);
        for (int i = 0; i < 31; i++) begin
            put_bit(w[i], 1'b1, '0);
        end
        check({name, " valid_before_last"}, {31'd0, bus.out_valid}, 32'd0);
        check({name, " wr_ptr_before_last"}, {27'd0, bus.wr_ptr}, 32'd31);
        put_bit(w[31], 1'b1, '0);
        exp_q.push_back(w);
        check({name, " valid_after_last"}, {31'd0, bus.out_valid}, 32'd1);
        check({name, " ready_in_hold"}, {31'd0, bus.in_ready}, 32'd0);
        check({name, " wr_ptr_wrapped"}, {27'd0, bus.wr_ptr}, 32'd0);
    endtask

    task automatic release_frame();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_valid_exclusive", {31'd0, bus.in_ready && bus.out_valid}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %h expected none", bus.out_lines);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("frame_lines", bus.out_lines, e);
`ifdef LANE_DEMUX_PARITY_EN
                    check("frame_parity", {31'd0, bus.out_parity}, {31'd0, ^e});
`endif
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_sel    = '0;
        bus.auto_inc  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // reset state
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst wr_ptr", {27'd0, bus.wr_ptr}, 32'd0);
        check("rst out_lines", bus.out_lines, 32'd0);
`ifdef LANE_DEMUX_PARITY_EN
        check("rst parity", {31'd0, bus.out_parity}, 32'd0);
`endif

        // auto mode 1,0,1,0,... -> 0x5555_5555
        send_word(32'h5555_5555, "auto_5555");
        check("auto_5555 lines", bus.out_lines, 32'h5555_5555);
        release_frame();
        check("after_release in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("after_release out_valid", {31'd0, bus.out_valid}, 32'd0);

        // direct mode descending, only lane 7 set
        for (int i = 31; i >= 0; i--) begin
            put_bit(i == 7, 1'b0, lane_sel_t'(i));
        end
        exp_q.push_back(32'h0000_0080);
        check("direct out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("direct lines", bus.out_lines, 32'h0000_0080);
        check("direct wr_ptr", {27'd0, bus.wr_ptr}, 32'd0);
        // stall 5 cycles with a write attempt on lane 0 that must be ignored
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        bus.in_sel   = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall lines", bus.out_lines, 32'h0000_0080);
        end
        bus.in_valid = 1'b0;
        release_frame();

        // lane 3 rewritten 4 times (last 0), then the other 31 lanes with 1
        put_bit(1'b1, 1'b0, 5'd3);
        put_bit(1'b1, 1'b0, 5'd3);
        put_bit(1'b1, 1'b0, 5'd3);
        put_bit(1'b0, 1'b0, 5'd3);
        for (int i = 0; i < 32; i++) begin
            if (i != 3) begin
                if (i == 31) begin
                    check("rewrite not_done", {31'd0, bus.out_valid}, 32'd0);
                    exp_q.push_back(32'hFFFF_FFF7);
                end
                put_bit(1'b1, 1'b0, lane_sel_t'(i));
            end
        end
        check("rewrite done", {31'd0, bus.out_valid}, 32'd1);
        check("rewrite lines", bus.out_lines, 32'hFFFF_FFF7);
        release_frame();

        // clear after 10 auto accepts of 0; accept in the clear cycle dropped
        for (int i = 0; i < 10; i++) begin
            put_bit(1'b0, 1'b1, '0);
        end
        check("pre_clear wr_ptr", {27'd0, bus.wr_ptr}, 32'd10);
        bus.clear = 1'b1;
        put_bit(1'b0, 1'b1, '0);
        bus.clear = 1'b0;
        check("clear wr_ptr", {27'd0, bus.wr_ptr}, 32'd0);
        check("clear lines", bus.out_lines, 32'hFFFF_FC00);
        check("clear out_valid", {31'd0, bus.out_valid}, 32'd0);
        send_word(32'hFFFF_FFFF, "post_clear");
        release_frame();

        // parity frames; in_valid during the handshake cycle is not accepted
        send_word(32'h0000_0003, "par3");
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bit    = 1'b1;
        bus.auto_inc  = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("handshake no_accept wr_ptr", {27'd0, bus.wr_ptr}, 32'd0);
        check("handshake no_accept lines", bus.out_lines, 32'h0000_0003);
        check("handshake in_ready", {31'd0, bus.in_ready}, 32'd1);
        w = 32'h0000_0007;
        put_bit(w[0], 1'b1, '0);
        check("next_frame first accept", {27'd0, bus.wr_ptr}, 32'd1);
        for (int i = 1; i < 32; i++) begin
            if (i == 31) exp_q.push_back(w);
            put_bit(w[i], 1'b1, '0);
        end
        check("par7 valid", {31'd0, bus.out_valid}, 32'd1);
        release_frame();

        // reset while in HOLD drops the frame
        for (int i = 0; i < 32; i++) begin
            put_bit(1'b1, 1'b1, '0);
        end
        check("pre_reset hold", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("hold_reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("hold_reset lines", bus.out_lines, 32'd0);
        check("hold_reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("hold_reset wr_ptr", {27'd0, bus.wr_ptr}, 32'd0);
        repeat (3) tick();
        check("no_valid_after_reset", {31'd0, bus.out_valid}, 32'd0);

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
